perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of event counters for the pipelined 16-bit processor. It generalises the fixed set of per-event special-purpose counters into one block. Tracked events: cycles, instructions executed, stall cycles, loads, stores, ALU instructions and control instructions. The datapath drives one event pulse per counter. Software and testbench observe the counters through a registered indexed read port, with a snapshot (shadow) copy, sticky overflow flags and preload.

## Interface
- WIDTH, 16, counter and data width in bits (2..32).
- NUM_CNT, 7, number of counters (1..2^IDX_W).
- IDX_W, 3, width of counter index ports.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cnt_en  input  1  global count enable; 0 freezes all counters.
- inc_en  input  NUM_CNT  per-counter event pulse; bit i increments counter i.
- clr  input  1  synchronous clear of all counters, shadows, overflow flags and snap_valid.
- snap  input  1  copy all live counters into shadow registers.
- wr_en  input  1  preload strobe.
- wr_idx  input  IDX_W  counter index to preload.
- wr_data  input  WIDTH  preload value.
- rd_idx  input  IDX_W  counter index to read.
- rd_sel  input  1  0 = live counter, 1 = shadow copy.
- rd_data  output  WIDTH  registered read data.
- rd_ovf  output  1  registered sticky overflow flag of the read counter.
- ovf_any  output  1  OR of all sticky overflow flags.
- snap_valid  output  1  high once a snapshot has been taken since the last clear or reset.

## Operation
- Per-cycle update of counter i, in priority order:
  - reset low: all state is 0.
  - clr: counter, shadow and ovf[i] go to 0; snap is ignored that cycle.
  - wr_en with wr_idx == i: counter loads wr_data and ovf[i] clears. An increment on i in the same cycle is dropped.
  - cnt_en & inc_en[i]: counter increments by 1, modulo 2^WIDTH.
  - Otherwise the counter holds.
- Overflow:
  - An increment from all-ones wraps to 0 and sets ovf[i].
  - ovf[i] stays set until clr, reset, or a preload of counter i.
- Snapshot:
  - snap (without clr) loads every shadow register with the live value present before this edge. Increments in the same cycle are not included.
  - snap_valid is set on that edge.
- Out-of-range indices:
  - wr_idx >= NUM_CNT: the write is ignored.
  - rd_idx >= NUM_CNT: rd_data = 0 and rd_ovf = 0.
- Read path:
  - rd_data and rd_ovf register the value selected by rd_idx/rd_sel as it stands before the edge.
  - rd_ovf always reports the sticky live flag, regardless of rd_sel.
- ovf_any is combinational from the flag register, with no extra latency.

## Timing
- Reset values: all counters, shadows and overflow flags are 0; rd_data = 0, rd_ovf = 0, ovf_any = 0, snap_valid = 0.
- Increment latency: an event at edge k is visible in the counter after edge k. It appears on rd_data after edge k+1 (read latency of 1 cycle).
- Preload latency: wr at edge k is readable on rd_data after edge k+1.
- Snapshot latency: a snap at edge k is visible on rd_data with rd_sel = 1 after edge k+1.
- Reset asserted mid-count: state clears immediately and asynchronously. Counting resumes on the first edge after reset deasserts.
- Simultaneous events on different counters are independent. There is no arbitration between counters.

## Test plan
- Reset: hold reset low with inc_en all ones and cnt_en = 1 -> rd_data = 0x0000, ovf_any = 0, snap_valid = 0. Release reset and count 5 cycles on counter 0 -> reading index 0 gives 0x0005.
- Freeze: count counter 2 for 3 cycles, drop cnt_en for 4 cycles with inc_en[2] = 1, then re-enable for 2 cycles -> counter 2 reads 0x0005.
- Wrap: preload counter 1 with 0xFFFE, then 2 increments -> 0x0000, rd_ovf = 1, ovf_any = 1. Preload 0x0010 -> rd_ovf = 0, ovf_any = 0.
- Snapshot: counter 3 at 0x0007 with an increment and snap in the same cycle -> shadow 0x0007, live 0x0008, snap_valid = 1.
- Priority: assert clr, wr_en (idx 4, 0x1234), snap and inc_en together -> counter 4 = 0, all shadows = 0, snap_valid = 0. Next cycle, wr_en alone together with inc_en[4] -> counter 4 = 0x1234.
- Out of range: with NUM_CNT = 7, read rd_idx = 7 -> rd_data = 0, rd_ovf = 0. Write wr_idx = 7 -> no counter changes. Repeat the suite with WIDTH = 8 -> wraps at 0xFF.

Source files
------------

// File: rtl/perf_counter_bank.sv
`default_nettype none
// ============================================================================
// perf_counter_bank: parametrised bank of event counters with snapshot
// shadows, sticky overflow flags, preload and a registered indexed read port.
// Revision: 1.0
// ============================================================================
module perf_counter_bank #(
  parameter int WIDTH   = 16,
  parameter int NUM_CNT = 7,
  parameter int IDX_W   = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cnt_en_i,
  input  logic [NUM_CNT-1:0] inc_en_i,
  input  logic               clr_i,
  input  logic               snap_i,
  input  logic               wr_en_i,
  input  logic [IDX_W-1:0]   wr_idx_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic [IDX_W-1:0]   rd_idx_i,
  input  logic               rd_sel_i,
  output logic [WIDTH-1:0]   rd_data_o,
  output logic               rd_ovf_o,
  output logic               ovf_any_o,
  output logic               snap_valid_o
);

  logic [WIDTH-1:0]   cnt_q [NUM_CNT];
  logic [WIDTH-1:0]   cnt_d [NUM_CNT];
  logic [WIDTH-1:0]   shd_q [NUM_CNT];
  logic [WIDTH-1:0]   shd_d [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic               snap_valid_q, snap_valid_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;
  logic               rd_ovf_q, rd_ovf_d;

  // Priority per counter: clear, then preload, then increment.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      shd_d[i] = shd_q[i];
      ovf_d[i] = ovf_q[i];
      if (clr_i) begin
        cnt_d[i] = '0;
        shd_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else begin
        if (snap_i) shd_d[i] = cnt_q[i];
        if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
          cnt_d[i] = wr_data_i;
          ovf_d[i] = 1'b0;
        end else if (cnt_en_i && inc_en_i[i]) begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
          if (&cnt_q[i]) ovf_d[i] = 1'b1;
        end
      end
    end
    snap_valid_d = clr_i ? 1'b0 : (snap_valid_q | snap_i);
  end

  // Indices with no matching counter fall through to zero.
  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx_i == IDX_W'(i)) begin
        rd_data_d = rd_sel_i ? shd_q[i] : cnt_q[i];
        rd_ovf_d  = ovf_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
        shd_q[i] <= '0;
      end
      ovf_q        <= '0;
      snap_valid_q <= 1'b0;
      rd_data_q    <= '0;
      rd_ovf_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
        shd_q[i] <= shd_d[i];
      end
      ovf_q        <= ovf_d;
      snap_valid_q <= snap_valid_d;
      rd_data_q    <= rd_data_d;
      rd_ovf_q     <= rd_ovf_d;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_ovf_o     = rd_ovf_q;
  assign ovf_any_o    = |ovf_q;
  assign snap_valid_o = snap_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
`default_nettype none
// ============================================================================
// tb_perf_counter_bank: directed self-checking bench for perf_counter_bank
// (16-bit bank plus an 8-bit bank for the narrow wrap case).
// Revision: 1.0
// ============================================================================
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cnt_en, clr, snap, wr_en, rd_sel;
  logic [6:0]  inc_en;
  logic [2:0]  wr_idx, rd_idx;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_ovf, ovf_any, snap_valid;

  logic        b_cnt_en, b_clr, b_snap, b_wr_en, b_rd_sel;
  logic [6:0]  b_inc_en;
  logic [2:0]  b_wr_idx, b_rd_idx;
  logic [7:0]  b_wr_data;
  logic [7:0]  b_rd_data;
  logic        b_rd_ovf, b_ovf_any, b_snap_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.WIDTH(16), .NUM_CNT(7), .IDX_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cnt_en_i(cnt_en), .inc_en_i(inc_en),
    .clr_i(clr), .snap_i(snap), .wr_en_i(wr_en), .wr_idx_i(wr_idx),
    .wr_data_i(wr_data), .rd_idx_i(rd_idx), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data), .rd_ovf_o(rd_ovf), .ovf_any_o(ovf_any),
    .snap_valid_o(snap_valid)
  );

  perf_counter_bank #(.WIDTH(8), .NUM_CNT(7), .IDX_W(3)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .cnt_en_i(b_cnt_en), .inc_en_i(b_inc_en),
    .clr_i(b_clr), .snap_i(b_snap), .wr_en_i(b_wr_en), .wr_idx_i(b_wr_idx),
    .wr_data_i(b_wr_data), .rd_idx_i(b_rd_idx), .rd_sel_i(b_rd_sel),
    .rd_data_o(b_rd_data), .rd_ovf_o(b_rd_ovf), .ovf_any_o(b_ovf_any),
    .snap_valid_o(b_snap_valid)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] idx, input logic sel);
    rd_idx = idx;
    rd_sel = sel;
    step(1);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_data = data;
    step(1);
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cnt_en = 1'b1; inc_en = 7'h7F; clr = 1'b0; snap = 1'b0;
    wr_en = 1'b0; wr_idx = 3'd0; wr_data = 16'h0; rd_idx = 3'd0; rd_sel = 1'b0;
    b_cnt_en = 1'b1; b_inc_en = 7'h0; b_clr = 1'b0; b_snap = 1'b0;
    b_wr_en = 1'b0; b_wr_idx = 3'd0; b_wr_data = 8'h0; b_rd_idx = 3'd0; b_rd_sel = 1'b0;

    // Reset held with every event active
    step(4);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_rd_ovf", 32'(rd_ovf), 32'h0);
    chk("reset_ovf_any", 32'(ovf_any), 32'h0);
    chk("reset_snap_valid", 32'(snap_valid), 32'h0);

    inc_en = 7'h00;
    rst_n  = 1'b1;
    inc_en = 7'h01;
    step(5);
    inc_en = 7'h00;
    rd(3'd0, 1'b0);
    chk("count5_c0", 32'(rd_data), 32'h5);

    // Freeze via cnt_en
    inc_en = 7'h04;
    step(3);
    cnt_en = 1'b0;
    step(4);
    cnt_en = 1'b1;
    step(2);
    inc_en = 7'h00;
    rd(3'd2, 1'b0);
    chk("freeze_c2", 32'(rd_data), 32'h5);
    rd(3'd0, 1'b0);
    chk("indep_c0", 32'(rd_data), 32'h5);

    // Wrap and overflow
    wr(3'd1, 16'hFFFE);
    inc_en = 7'h02;
    step(1);
    inc_en = 7'h00;
    rd(3'd1, 1'b0);
    chk("pre_wrap_c1", 32'(rd_data), 32'hFFFF);
    chk("pre_wrap_ovf", 32'(rd_ovf), 32'h0);
    inc_en = 7'h02;
    step(1);
    inc_en = 7'h00;
    rd(3'd1, 1'b0);
    chk("wrap_c1", 32'(rd_data), 32'h0);
    chk("wrap_rd_ovf", 32'(rd_ovf), 32'h1);
    chk("wrap_ovf_any", 32'(ovf_any), 32'h1);
    rd(3'd1, 1'b1);
    chk("ovf_on_shadow_sel", 32'(rd_ovf), 32'h1);
    wr(3'd1, 16'h0010);
    chk("preload_ovf_any", 32'(ovf_any), 32'h0);
    rd(3'd1, 1'b0);
    chk("preload_c1", 32'(rd_data), 32'h0010);
    chk("preload_rd_ovf", 32'(rd_ovf), 32'h0);

    // Snapshot with concurrent increment
    wr(3'd3, 16'h0007);
    chk("snap_valid_before", 32'(snap_valid), 32'h0);
    inc_en = 7'h08; snap = 1'b1;
    step(1);
    inc_en = 7'h00; snap = 1'b0;
    chk("snap_valid_set", 32'(snap_valid), 32'h1);
    rd(3'd3, 1'b1);
    chk("snap_shadow_c3", 32'(rd_data), 32'h0007);
    rd(3'd3, 1'b0);
    chk("snap_live_c3", 32'(rd_data), 32'h0008);
    rd(3'd0, 1'b1);
    chk("snap_shadow_c0", 32'(rd_data), 32'h0005);
    rd(3'd1, 1'b1);
    chk("snap_shadow_c1", 32'(rd_data), 32'h0010);

    // Clear wins over write, snap and increment
    clr = 1'b1; snap = 1'b1; wr_en = 1'b1; wr_idx = 3'd4; wr_data = 16'h1234; inc_en = 7'h10;
    step(1);
    clr = 1'b0; snap = 1'b0;
    chk("clr_snap_valid", 32'(snap_valid), 32'h0);
    step(1);
    wr_en = 1'b0; inc_en = 7'h00;
    rd(3'd4, 1'b0);
    chk("wr_over_inc_c4", 32'(rd_data), 32'h1234);
    rd(3'd3, 1'b1);
    chk("clr_shadow_c3", 32'(rd_data), 32'h0);
    rd(3'd3, 1'b0);
    chk("clr_live_c3", 32'(rd_data), 32'h0);
    rd(3'd0, 1'b0);
    chk("clr_live_c0", 32'(rd_data), 32'h0);

    // Out-of-range index
    wr(3'd6, 16'h00AA);
    rd(3'd7, 1'b0);
    chk("oor_rd_data", 32'(rd_data), 32'h0);
    chk("oor_rd_ovf", 32'(rd_ovf), 32'h0);
    wr(3'd7, 16'hABCD);
    rd(3'd4, 1'b0);
    chk("oor_wr_c4", 32'(rd_data), 32'h1234);
    rd(3'd6, 1'b0);
    chk("oor_wr_c6", 32'(rd_data), 32'h00AA);
    rd(3'd0, 1'b0);
    chk("oor_wr_c0", 32'(rd_data), 32'h0);

    // Reset asserted mid-count clears asynchronously
    inc_en = 7'h10;
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd_data", 32'(rd_data), 32'h0);
    step(1);
    inc_en = 7'h00;
    rst_n = 1'b1;
    rd(3'd4, 1'b0);
    chk("after_rst_c4", 32'(rd_data), 32'h0);

    // 8-bit bank wraps at 0xFF
    b_wr_en = 1'b1; b_wr_idx = 3'd1; b_wr_data = 8'hFE;
    step(1);
    b_wr_en = 1'b0; b_inc_en = 7'h02;
    step(1);
    b_inc_en = 7'h00; b_rd_idx = 3'd1;
    step(1);
    chk("w8_pre_wrap", 32'(b_rd_data), 32'hFF);
    b_inc_en = 7'h02;
    step(1);
    b_inc_en = 7'h00;
    step(1);
    chk("w8_wrap", 32'(b_rd_data), 32'h00);
    chk("w8_rd_ovf", 32'(b_rd_ovf), 32'h1);
    chk("w8_ovf_any", 32'(b_ovf_any), 32'h1);
    b_rd_idx = 3'd7;
    step(1);
    chk("w8_oor_rd_ovf", 32'(b_rd_ovf), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
